// File: rtl/alarm_minigame_ctrl_pkg.sv
// Shared types and constants for the alarm mini-game controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, alarm_state output codes, BCD/time widths,
// mini-game width and a BCD minute-add helper used by the snooze path.
package alarm_minigame_ctrl_pkg;

  localparam int BCD_W      = 4;
  localparam int TIME_W     = 4 * BCD_W;
  localparam int MINIGAME_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_GAME    = 2'd2,
    ST_OFF     = 2'd3
  } state_e;

  localparam logic [2:0] AS_IDLE    = 3'b000;
  localparam logic [2:0] AS_RINGING = 3'b001;
  localparam logic [2:0] AS_GAME    = 3'b010;
  localparam logic [2:0] AS_OFF     = 3'b100;

  function automatic logic [2:0] state_code(input state_e s);
    logic [2:0] code;
    case (s)
      ST_RINGING: code = AS_RINGING;
      ST_GAME:    code = AS_GAME;
      ST_OFF:     code = AS_OFF;
      default:    code = AS_IDLE;
    endcase
    return code;
  endfunction

  // Adds 'add' minutes to a BCD {M10,M1} pair, wrapping 59 -> 00.
  function automatic logic [7:0] bcd_min_add(input logic [7:0] mm, input int add);
    int mins;
    mins = (10 * int'(mm[7:4]) + int'(mm[3:0]) + add) % 60;
    return {4'(mins / 10), 4'(mins % 10)};
  endfunction

endpackage

// File: rtl/alarm_minigame_ctrl_if.sv
// Bundle of the alarm mini-game service signals (everything except clk/rst).
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// master: drives time/alarm/switch/button inputs, observes LEDs/state.
// slave : the controller, consuming inputs and driving LEDs/state/score.
interface alarm_minigame_ctrl_if;
  import alarm_minigame_ctrl_pkg::*;

  logic                  spdt4;
  logic [TIME_W-1:0]     current_time;
  logic [TIME_W-1:0]     alarm_time;
  logic                  push_m;
  logic                  push_d;
  logic [MINIGAME_W-1:0] mini_game;
  logic [MINIGAME_W-1:0] mini_game_led;
  logic [2:0]            alarm_state;
  logic                  alarm_blink;
  logic [3:0]            score;
  logic                  finish4;

  modport master (
    output spdt4, current_time, alarm_time, push_m, push_d, mini_game,
    input  mini_game_led, alarm_state, alarm_blink, score, finish4
  );

  modport slave (
    input  spdt4, current_time, alarm_time, push_m, push_d, mini_game,
    output mini_game_led, alarm_state, alarm_blink, score, finish4
  );

endinterface

// File: rtl/alarm_minigame_ctrl_minigame_target_lfsr.sv
// Picks the mini-game target: 8-bit LFSR, mod-10 reduction, one-hot decode.
// Latency: new target visible the cycle after step_i is sampled high.
// Backpressure: none; every step_i pulse is accepted.
// Ports: clk, rst (async, active high), step_i (reload strobe),
//        led_o (one-hot of the current target).
module minigame_target_lfsr
  import alarm_minigame_ctrl_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_i,
  output logic [MINIGAME_W-1:0] led_o
);

  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] target_q, target_d;
  logic [3:0] pick_raw, pick_alt;
  logic [8:0] lfsr_inc;
  logic [MINIGAME_W-1:0] one;

  always_comb begin
    lfsr_inc = {1'b0, lfsr_q} + 9'd1;
    pick_raw = 4'(lfsr_q % 8'd10);
    // 9-bit increment so 255+1 reduces as 256, not 0.
    pick_alt = 4'(lfsr_inc % 9'd10);
    lfsr_d   = lfsr_q;
    target_d = target_q;
    if (step_i) begin
      // Fibonacci form of x^8+x^6+x^5+x^4+1.
      lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      // Never repeat the previous target back to back.
      target_d = (pick_raw == target_q) ? pick_alt : pick_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q   <= LFSR_SEED;
      target_q <= 4'd0;
    end else begin
      lfsr_q   <= lfsr_d;
      target_q <= target_d;
    end
  end

  assign one   = {{(MINIGAME_W-1){1'b0}}, 1'b1};
  assign led_o = one << target_q;

endmodule

// File: rtl/alarm_minigame_ctrl.sv
// Alarm compare + ring + switch-matching mini-game to silence the alarm.
// Latency: outputs registered; state/score/finish4 change on the transition edge.
// Backpressure: none; inputs are sampled every cycle.
// Ports: clk, rst (async, active high), ctl_if (slave modport: spdt4,
//   current_time, alarm_time, push_m, push_d, mini_game in; mini_game_led,
//   alarm_state, alarm_blink, score, finish4 out).
// Optional: define ALARM_SNOOZE_EN to enable push_d snooze (+SNOOZE_MIN minutes).
module alarm_minigame_ctrl
  import alarm_minigame_ctrl_pkg::*;
#(
  parameter int         ROUNDS         = 3,
  parameter int         TIMEOUT_CYCLES = 5,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         SNOOZE_MIN     = 5
) (
  input logic                  clk,
  input logic                  rst,
  alarm_minigame_ctrl_if.slave ctl_if
);

  state_e                state_q, state_d;
  logic [2:0]            alarm_state_q, alarm_state_d;
  logic                  blink_q, blink_d;
  logic [3:0]            score_q, score_d;
  logic [7:0]            timer_q, timer_d;
  logic                  finish_q, finish_d;
  logic                  push_m_q;
  logic [MINIGAME_W-1:0] mini_game_q;
  logic                  eq_q;

  logic                  eq_now;
  logic                  push_m_rise;
  logic [MINIGAME_W-1:0] tog;
  logic [MINIGAME_W-1:0] led_raw;
  logic                  lfsr_step;
  logic                  snooze_hit;
  logic                  snooze_req;
  logic [TIME_W-1:0]     eff_alarm;

  minigame_target_lfsr #(.LFSR_SEED(LFSR_SEED)) u_target (
    .clk   (clk),
    .rst   (rst),
    .step_i(lfsr_step),
    .led_o (led_raw)
  );

`ifdef ALARM_SNOOZE_EN
  logic              push_d_q;
  logic              snoozed_q, snoozed_d;
  logic [TIME_W-1:0] snooze_q, snooze_d;
  logic [TIME_W-1:0] alarm_prev_q;

  assign snooze_hit = ctl_if.push_d & ~push_d_q;

  always_comb begin
    snoozed_d = snoozed_q;
    snooze_d  = snooze_q;
    // A new alarm setting always cancels a pending snooze.
    if (ctl_if.alarm_time != alarm_prev_q) begin
      snoozed_d = 1'b0;
    end else if (snooze_req) begin
      snoozed_d = 1'b1;
      snooze_d  = {bcd_min_add(ctl_if.current_time[15:8], SNOOZE_MIN),
                   ctl_if.current_time[7:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_d_q     <= 1'b0;
      snoozed_q    <= 1'b0;
      snooze_q     <= '0;
      alarm_prev_q <= '0;
    end else begin
      push_d_q     <= ctl_if.push_d;
      snoozed_q    <= snoozed_d;
      snooze_q     <= snooze_d;
      alarm_prev_q <= ctl_if.alarm_time;
    end
  end

  assign eff_alarm = snoozed_q ? snooze_q : ctl_if.alarm_time;
`else
  logic unused_snooze;
  assign unused_snooze = ^{ctl_if.push_d, snooze_req, 32'(SNOOZE_MIN)};
  assign snooze_hit    = 1'b0;
  assign eff_alarm     = ctl_if.alarm_time;
`endif

  assign eq_now      = (ctl_if.current_time == eff_alarm);
  assign push_m_rise = ctl_if.push_m & ~push_m_q;
  assign tog         = ctl_if.mini_game ^ mini_game_q;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    timer_d    = timer_q;
    lfsr_step  = 1'b0;
    snooze_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        score_d = 4'd0;
        timer_d = 8'd0;
        // Ring only on the rising edge of the time match.
        if (ctl_if.spdt4 && eq_now && !eq_q) state_d = ST_RINGING;
      end
      ST_RINGING: begin
        if (!ctl_if.spdt4) begin
          state_d = ST_IDLE;
        end else if (snooze_hit) begin
          state_d    = ST_IDLE;
          snooze_req = 1'b1;
        end else if (push_m_rise) begin
          state_d   = ST_GAME;
          score_d   = 4'd0;
          timer_d   = 8'd0;
          lfsr_step = 1'b1;
        end
      end
      ST_GAME: begin
        if (!ctl_if.spdt4) begin
          state_d = ST_IDLE;
          score_d = 4'd0;
          timer_d = 8'd0;
        end else if (tog != '0) begin
          timer_d   = 8'd0;
          lfsr_step = 1'b1;
          // Exact match against the one-hot target: multi-bit toggles miss.
          if (tog == led_raw) begin
            score_d = score_q + 4'd1;
            if (score_q + 4'd1 == 4'(ROUNDS)) state_d = ST_OFF;
          end else begin
            score_d = 4'd0;
          end
        end else if (timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
          timer_d   = 8'd0;
          score_d   = 4'd0;
          lfsr_step = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_OFF: begin
        if (!ctl_if.spdt4) begin
          state_d = ST_IDLE;
          score_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    blink_d       = (state_d == ST_RINGING || state_d == ST_GAME) ? ~blink_q : 1'b0;
    finish_d      = (state_d == ST_OFF) && (state_q != ST_OFF);
    alarm_state_d = state_code(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      alarm_state_q <= AS_IDLE;
      blink_q       <= 1'b0;
      score_q       <= 4'd0;
      timer_q       <= 8'd0;
      finish_q      <= 1'b0;
      push_m_q      <= 1'b0;
      mini_game_q   <= '0;
      eq_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      alarm_state_q <= alarm_state_d;
      blink_q       <= blink_d;
      score_q       <= score_d;
      timer_q       <= timer_d;
      finish_q      <= finish_d;
      push_m_q      <= ctl_if.push_m;
      mini_game_q   <= ctl_if.mini_game;
      eq_q          <= eq_now;
    end
  end

  assign ctl_if.mini_game_led = (state_q == ST_GAME) ? led_raw : '0;
  assign ctl_if.alarm_state   = alarm_state_q;
  assign ctl_if.alarm_blink   = blink_q;
  assign ctl_if.score         = score_q;
  assign ctl_if.finish4       = finish_q;

endmodule

// File: tb/tb_alarm_minigame_ctrl.sv
// Directed bench for alarm_minigame_ctrl with a small target-picking model.
// Latency: n/a.
// Backpressure: n/a.
module tb_alarm_minigame_ctrl;
  import alarm_minigame_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] m_lfsr;
  logic [3:0] m_tgt;
  logic [3:0] m_score;

  alarm_minigame_ctrl_if ifc ();

  alarm_minigame_ctrl #(
    .ROUNDS(3), .TIMEOUT_CYCLES(5), .LFSR_SEED(8'hA5), .SNOOZE_MIN(5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ctl_if(ifc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] onehot(input logic [3:0] i);
    logic [9:0] v;
    v = 10'd1;
    return v << i;
  endfunction

  // Spec model of a target reload: pick from current LFSR, then step it.
  task automatic model_reload();
    logic [3:0] p;
    logic [8:0] inc;
    p = 4'(m_lfsr % 8'd10);
    if (p == m_tgt) begin
      inc = {1'b0, m_lfsr} + 9'd1;
      p   = 4'(inc % 9'd10);
    end
    m_tgt  = p;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic ring_up();
    ifc.spdt4        = 1'b1;
    ifc.current_time = 16'h0106;
    tick();
    ifc.current_time = 16'h0105;
    tick();
    check_eq("ring_up_state", 16'(ifc.alarm_state), 16'(AS_RINGING));
  endtask

  task automatic start_game();
    ifc.push_m = 1'b1;
    tick();
    ifc.push_m = 1'b0;
    model_reload();
    m_score = 4'd0;
    check_eq("game_state", 16'(ifc.alarm_state), 16'(AS_GAME));
    check_eq("game_led", 16'(ifc.mini_game_led), 16'(onehot(m_tgt)));
    check_eq("game_score0", 16'(ifc.score), 16'd0);
  endtask

  task automatic toggle(input logic [9:0] mask);
    ifc.mini_game = ifc.mini_game ^ mask;
    tick();
  endtask

  task automatic hit();
    toggle(onehot(m_tgt));
    model_reload();
    m_score = m_score + 4'd1;
    check_eq("hit_score", 16'(ifc.score), 16'(m_score));
    if (m_score < 4'd3) check_eq("hit_led", 16'(ifc.mini_game_led), 16'(onehot(m_tgt)));
  endtask

  initial begin
    rst              = 1'b1;
    m_lfsr           = 8'hA5;
    m_tgt            = 4'd0;
    m_score          = 4'd0;
    ifc.spdt4        = 1'b0;
    ifc.current_time = 16'h0100;
    ifc.alarm_time   = 16'h0105;
    ifc.push_m       = 1'b0;
    ifc.push_d       = 1'b0;
    ifc.mini_game    = 10'd0;
    tick();
    tick();
    check_eq("rst_state", 16'(ifc.alarm_state), 16'd0);
    check_eq("rst_led", 16'(ifc.mini_game_led), 16'd0);
    check_eq("rst_blink", 16'(ifc.alarm_blink), 16'd0);
    check_eq("rst_score", 16'(ifc.score), 16'd0);
    check_eq("rst_finish", 16'(ifc.finish4), 16'd0);
    rst = 1'b0;

    // Count up to the alarm time.
    ifc.spdt4 = 1'b1;
    for (int s = 0; s < 5; s++) begin
      ifc.current_time = 16'h0100 + 16'(s);
      tick();
    end
    check_eq("pre_match_idle", 16'(ifc.alarm_state), 16'(AS_IDLE));
    ifc.current_time = 16'h0105;
    tick();
    check_eq("match_ring", 16'(ifc.alarm_state), 16'(AS_RINGING));
    check_eq("blink_1", 16'(ifc.alarm_blink), 16'd1);
    tick();
    check_eq("blink_0", 16'(ifc.alarm_blink), 16'd0);
    check_eq("ring_hold", 16'(ifc.alarm_state), 16'(AS_RINGING));

    // Drop arm while ringing, re-arm with time held at the alarm: no retrigger.
    ifc.spdt4 = 1'b0;
    tick();
    check_eq("ring_drop_idle", 16'(ifc.alarm_state), 16'(AS_IDLE));
    check_eq("ring_drop_fin", 16'(ifc.finish4), 16'd0);
    ifc.spdt4 = 1'b1;
    tick();
    tick();
    check_eq("held_no_retrig", 16'(ifc.alarm_state), 16'(AS_IDLE));

    // Win the game in three hits.
    ring_up();
    start_game();
    hit();
    hit();
    hit();
    check_eq("off_state", 16'(ifc.alarm_state), 16'(AS_OFF));
    check_eq("off_finish", 16'(ifc.finish4), 16'd1);
    check_eq("off_led", 16'(ifc.mini_game_led), 16'd0);
    check_eq("off_blink", 16'(ifc.alarm_blink), 16'd0);
    tick();
    check_eq("finish_once", 16'(ifc.finish4), 16'd0);
    check_eq("off_stays", 16'(ifc.alarm_state), 16'(AS_OFF));
    ifc.spdt4 = 1'b0;
    tick();
    check_eq("off_to_idle", 16'(ifc.alarm_state), 16'(AS_IDLE));

    // Wrong switch, multi-toggle and timeout each reset the score.
    ring_up();
    start_game();
    hit();
    hit();
    toggle(onehot(4'((m_tgt + 4'd3) % 4'd10)));
    model_reload();
    check_eq("wrong_score", 16'(ifc.score), 16'd0);
    check_eq("wrong_led", 16'(ifc.mini_game_led), 16'(onehot(m_tgt)));
    check_eq("wrong_state", 16'(ifc.alarm_state), 16'(AS_GAME));
    m_score = 4'd0;
    hit();
    toggle(onehot(m_tgt) | onehot(4'((m_tgt + 4'd1) % 4'd10)));
    model_reload();
    check_eq("multi_score", 16'(ifc.score), 16'd0);
    check_eq("multi_led", 16'(ifc.mini_game_led), 16'(onehot(m_tgt)));
    m_score = 4'd0;
    hit();
    for (int i = 0; i < 4; i++) tick();
    check_eq("pre_timeout_score", 16'(ifc.score), 16'd1);
    check_eq("pre_timeout_led", 16'(ifc.mini_game_led), 16'(onehot(m_tgt)));
    tick();
    model_reload();
    check_eq("timeout_score", 16'(ifc.score), 16'd0);
    check_eq("timeout_led", 16'(ifc.mini_game_led), 16'(onehot(m_tgt)));
    check_eq("timeout_state", 16'(ifc.alarm_state), 16'(AS_GAME));

    // Arm dropped mid-game.
    ifc.spdt4 = 1'b0;
    tick();
    check_eq("game_drop_idle", 16'(ifc.alarm_state), 16'(AS_IDLE));
    check_eq("game_drop_led", 16'(ifc.mini_game_led), 16'd0);
    check_eq("game_drop_fin", 16'(ifc.finish4), 16'd0);

    // Asynchronous reset in the middle of a round.
    ring_up();
    start_game();
    #3;
    rst              = 1'b1;
    ifc.current_time = 16'h0106;
    #1;
    check_eq("arst_state", 16'(ifc.alarm_state), 16'd0);
    check_eq("arst_led", 16'(ifc.mini_game_led), 16'd0);
    check_eq("arst_score", 16'(ifc.score), 16'd0);
    check_eq("arst_blink", 16'(ifc.alarm_blink), 16'd0);
    m_lfsr = 8'hA5;
    m_tgt  = 4'd0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_eq("post_rst_idle", 16'(ifc.alarm_state), 16'(AS_IDLE));
    ifc.current_time = 16'h0105;
    tick();
    check_eq("post_rst_ring", 16'(ifc.alarm_state), 16'(AS_RINGING));
    start_game();
    check_eq("seed_target", 16'(ifc.mini_game_led), 16'h0020);
    ifc.spdt4 = 1'b0;
    tick();

`ifdef ALARM_SNOOZE_EN
    ifc.alarm_time   = 16'h5810;
    ifc.current_time = 16'h5809;
    ifc.spdt4        = 1'b1;
    tick();
    ifc.current_time = 16'h5810;
    tick();
    check_eq("snz_ring", 16'(ifc.alarm_state), 16'(AS_RINGING));
    ifc.push_d = 1'b1;
    tick();
    ifc.push_d = 1'b0;
    check_eq("snz_idle", 16'(ifc.alarm_state), 16'(AS_IDLE));
    ifc.current_time = 16'h5811;
    tick();
    ifc.current_time = 16'h5810;
    tick();
    check_eq("snz_old_ignored", 16'(ifc.alarm_state), 16'(AS_IDLE));
    ifc.current_time = 16'h0309;
    tick();
    check_eq("snz_before", 16'(ifc.alarm_state), 16'(AS_IDLE));
    ifc.current_time = 16'h0310;
    tick();
    check_eq("snz_wrap_ring", 16'(ifc.alarm_state), 16'(AS_RINGING));
`else
    ring_up();
    ifc.push_d = 1'b1;
    tick();
    ifc.push_d = 1'b0;
    check_eq("push_d_ignored", 16'(ifc.alarm_state), 16'(AS_RINGING));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_minigame_ctrl.md
Name: alarm_minigame_ctrl

Overview:
- Service-4 stage that sits downstream of the time counter and the alarm-set service.
- Compares the running MM:SS time against the stored alarm and rings while armed.
- Once ringing, the user must win a switch-matching mini-game to silence the alarm.
- Drives the 10 mini-game LEDs, the alarm-state code and the finish4 pulse consumed by the top-level LED/segment logic.

Parameters:
- ROUNDS, 3: consecutive correct hits needed to silence the alarm (1..9).
- TIMEOUT_CYCLES, 5: clk cycles allowed per round before the round is lost.
- LFSR_SEED, 8'hA5: non-zero reset seed of the target-picking LFSR.
- SNOOZE_MIN, 5: minutes added on snooze (used only with the optional feature).

Ports:
- clk  in  1  service clock (1 Hz tick domain, same clk as the time counter)
- reset  in  1  asynchronous active-high reset
- spdt4  in  1  service-4 arm switch (level)
- current_time  in  16  current time, BCD {M10,M1,S10,S1}
- alarm_time  in  16  alarm time, BCD {M10,M1,S10,S1}
- push_m  in  1  middle button (level; edge-detected inside)
- push_d  in  1  down button (snooze; used only with SNOOZE feature)
- mini_game  in  10  mini-game switches
- mini_game_led  out  10  one-hot target LED during game, else 0
- alarm_state  out  3  000 idle, 001 ringing, 010 mini-game, 100 off
- alarm_blink  out  1  toggles every clk while ringing or in game, else 0
- score  out  4  correct hits in current attempt, binary
- finish4  out  1  one-cycle pulse on entering OFF

Behaviour:
- Reset (async, any state): FSM=IDLE; all outputs 0; LFSR=LFSR_SEED; edge/prev registers capture 0; effective alarm = alarm_time.
- Edge detect: push_m_rise = push_m & ~push_m_q. Switch toggle: any bit of mini_game ^ mini_game_q; toggled index = lowest changed bit.
- IDLE:
  - spdt4=1 and current_time==eff_alarm, with that equality false on the previous cycle -> RINGING.
  - spdt4=0 holds IDLE.
- RINGING:
  - alarm_blink toggles each cycle.
  - push_m_rise -> GAME: score=0, timer=0, target=LFSR mod 10 loaded on the same edge.
  - spdt4 falling -> IDLE.
- GAME:
  - mini_game_led = one-hot(target).
  - Each cycle the timer increments.
  - Toggle at index == target: score+1, timer=0, LFSR steps, new target. If score+1 == ROUNDS -> OFF.
  - Toggle at a wrong index: score=0, timer=0, new target.
  - timer == TIMEOUT_CYCLES-1 with no toggle: score=0, new target, stay in GAME.
  - Multiple bits toggled in one cycle: treated as wrong.
  - spdt4=0 -> IDLE.
- OFF:
  - finish4=1 for exactly the entry cycle; LEDs 0, blink 0.
  - Stays in OFF until spdt4=0, then IDLE. Re-arming rings only at the next equality edge.
- LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, steps only on target reload. Target = lfsr % 10. If the result equals the previous target, use (lfsr+1)%10.
- alarm_state is registered and changes on the cycle of the state transition.
- Equality match uses the full 16 bits; no BCD validity check.

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined: in RINGING, a push_d rising edge sets eff_alarm = current minutes + SNOOZE_MIN, seconds kept.
  - BCD minute add wraps 59->00 (e.g. 58:10 + 5 -> 03:10).
  - FSM returns to IDLE.
  - eff_alarm reloads from alarm_time on reset or when alarm_time changes.
- Undefined: push_d is ignored, eff_alarm == alarm_time always, and the port remains.

Decomposition:
- Shared package: state encodings (ST_IDLE/RINGING/GAME/OFF), alarm_state codes, BCD digit width, MINIGAME_W=10.
- One sub-module, minigame_target_lfsr: LFSR, mod-10 reduction and one-hot LED decode, with step/load handshake.

Test Plan:
- alarm_time=16'h0105, spdt4=1, count current_time up to 01:05 -> alarm_state=001 on the match edge; blink toggles; no retrigger at 01:05 held.
- RINGING, push_m pulse, then toggle the correct switch 3 times within 5 cycles each -> score 1,2,3; finish4 pulses once; alarm_state=100; led=0.
- GAME with score=2, toggle a wrong switch -> score=0 and a new one-hot target, still 010; 5 idle cycles -> timeout resets score.
- GAME, assert reset mid-round -> immediately IDLE, outputs 0, LFSR=8'hA5; after release no ring until the next equality edge.
- spdt4 dropped during RINGING and during GAME -> IDLE next edge, led=0, no finish4.
- ALARM_SNOOZE_EN, alarm 58:10, push_d in RINGING -> IDLE; rings again at 03:10 not before; wrap verified.
